// File: rtl/cci_mpf_shim_arb_sched.sv
// Round-robin request scheduler with per-port in-flight limits and a drain handshake.
// Optional per-port grant statistics are built when CCI_MPF_SHIM_ARB_SCHED_STATS_EN is defined.
module cci_mpf_shim_arb_sched #(
  parameter int NUM_PORTS       = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic                         tx_almost_full,
  input  logic                         rsp_valid,
  input  logic [$clog2(NUM_PORTS)-1:0] rsp_port,
  input  logic                         drain_req,
  input  logic [$clog2(NUM_PORTS)-1:0] stat_sel,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
  output logic                         drained,
  output logic                         err_underflow,
  output logic [15:0]                  stat_cnt,
  output logic [1:0]                   dbg_state
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  // Handshake: grant[p] is the dequeue strobe for port p; a requester holding
  // req_valid[p] high sees its request consumed in any cycle where grant[p]=1.
  state_t             state;
  logic [IDX_W-1:0]   last_winner;
  logic [CNT_W-1:0]   outstanding     [NUM_PORTS];
  logic [CNT_W-1:0]   outstanding_nxt [NUM_PORTS];
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] rsp_hit;
  logic               underflow;
  logic               all_zero_nxt;

  assign dbg_state = state;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = req_valid[p] && (outstanding[p] < CNT_W'(MAX_OUTSTANDING)) &&
                    !tx_almost_full && (state == ST_RUN);
      rsp_hit[p]  = rsp_valid && (rsp_port == IDX_W'(p));
    end
  end

  // Search begins one past the last winner so every port gets a turn.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_l;
    logic             found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    idx_l     = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx   = (int'(last_winner) + i) % NUM_PORTS;
      idx_l = IDX_W'(idx);
      if (!found && eligible[idx_l]) begin
        found        = 1'b1;
        grant[idx_l] = 1'b1;
        grant_idx    = idx_l;
      end
    end
  end

  always_comb begin
    underflow    = 1'b0;
    all_zero_nxt = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      outstanding_nxt[p] = outstanding[p];
      if (grant[p] && !rsp_hit[p]) begin
        outstanding_nxt[p] = outstanding[p] + CNT_W'(1);
      end else if (rsp_hit[p] && !grant[p]) begin
        if (outstanding[p] == '0) begin
          underflow = 1'b1;
        end else begin
          outstanding_nxt[p] = outstanding[p] - CNT_W'(1);
        end
      end
      if (outstanding_nxt[p] != '0) begin
        all_zero_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_RUN;
      drained       <= 1'b0;
      last_winner   <= IDX_W'(NUM_PORTS - 1);
      err_underflow <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        outstanding[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        outstanding[p] <= outstanding_nxt[p];
      end
      if (|grant) begin
        last_winner <= grant_idx;
      end
      if (underflow) begin
        err_underflow <= 1'b1;
      end
      // Drain completion looks at counts after this cycle's grant/response updates.
      case (state)
        ST_RUN: begin
          if (drain_req) begin
            if (all_zero_nxt) begin
              state   <= ST_DRAINED;
              drained <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!drain_req) begin
            state <= ST_RUN;
          end else if (all_zero_nxt) begin
            state   <= ST_DRAINED;
            drained <= 1'b1;
          end
        end
        ST_DRAINED: begin
          if (!drain_req) begin
            state   <= ST_RUN;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= ST_RUN;
          drained <= 1'b0;
        end
      endcase
    end
  end

`ifdef CCI_MPF_SHIM_ARB_SCHED_STATS_EN
  logic [15:0] stat_q [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        stat_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant[p] && (stat_q[p] != 16'hFFFF)) begin
          stat_q[p] <= stat_q[p] + 16'd1;
        end
      end
    end
  end

  assign stat_cnt = (int'(stat_sel) < NUM_PORTS) ? stat_q[stat_sel] : 16'd0;
`else
  logic stat_sel_unused;
  assign stat_sel_unused = ^stat_sel;
  assign stat_cnt        = 16'd0;
`endif

endmodule

// File: tb/tb_cci_mpf_shim_arb_sched.sv
// Bench for cci_mpf_shim_arb_sched: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the scheduler.
module tb_cci_mpf_shim_arb_sched;

  localparam int N    = 4;
  localparam int MAXO = 4;
`ifdef CCI_MPF_SHIM_ARB_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // clock / reset
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid      = '0;
  logic         tx_almost_full = 1'b0;
  logic         rsp_valid      = 1'b0;
  logic [1:0]   rsp_port       = '0;
  logic         drain_req      = 1'b0;
  logic [1:0]   stat_sel       = '0;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         drained;
  logic         err_underflow;
  logic [15:0]  stat_cnt;
  logic [1:0]   dbg_state;

  cci_mpf_shim_arb_sched #(.NUM_PORTS(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .tx_almost_full(tx_almost_full),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .drain_req(drain_req), .stat_sel(stat_sel),
    .grant(grant), .grant_idx(grant_idx), .drained(drained), .err_underflow(err_underflow),
    .stat_cnt(stat_cnt), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: 0=run, 1=drain, 2=drained
  int m_out [N];
  int m_stat[N];
  int m_lw;
  int m_state;
  bit m_err;
  int m_win;
  logic [N-1:0] exp_grant;
  logic [1:0]   exp_idx;
  logic         exp_drained, exp_err;
  logic [15:0]  exp_stat;
  logic [N-1:0] exp_q[$];

  function automatic void model_reset();
    for (int p = 0; p < N; p++) begin
      m_out[p]  = 0;
      m_stat[p] = 0;
    end
    m_lw = N - 1; m_state = 0; m_err = 1'b0;
  endfunction

  function automatic void predict();
    m_win = -1;
    if (m_state == 0 && !tx_almost_full) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_lw + k) % N;
        if (m_win < 0 && req_valid[p] && m_out[p] < MAXO) m_win = p;
      end
    end
    exp_grant   = (m_win < 0) ? '0 : N'(1 << m_win);
    exp_idx     = (m_win < 0) ? 2'd0 : 2'(m_win);
    exp_drained = (m_state == 2);
    exp_err     = m_err;
    exp_stat    = STATS ? 16'(m_stat[stat_sel]) : 16'd0;
  endfunction

  function automatic void model_update();
    int total;
    total = 0;
    for (int p = 0; p < N; p++) begin
      bit inc, dec;
      inc = (p == m_win);
      dec = rsp_valid && (int'(rsp_port) == p);
      if (inc && !dec) m_out[p]++;
      else if (dec && !inc) begin
        if (m_out[p] == 0) m_err = 1'b1;
        else m_out[p]--;
      end
      if (inc && m_stat[p] < 65535) m_stat[p]++;
      total += m_out[p];
    end
    if (m_win >= 0) m_lw = m_win;
    case (m_state)
      0: if (drain_req) m_state = (total == 0) ? 2 : 1;
      1: if (!drain_req) m_state = 0; else if (total == 0) m_state = 2;
      default: if (!drain_req) m_state = 0;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input logic [N-1:0] rv, input logic taf, input logic rvld,
                       input logic [1:0] rp, input logic drn);
    req_valid = rv; tx_almost_full = taf; rsp_valid = rvld; rsp_port = rp; drain_req = drn;
    #1;
    predict();
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_update();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive('0, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive('0, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    n_checks++;
    if ({grant, grant_idx, drained, err_underflow, stat_cnt} !== '0)
      $display("FAIL reset_outputs: got g=%b i=%0d d=%b e=%b s=%0h exp all zero",
               grant, grant_idx, drained, err_underflow, stat_cnt);
    else n_pass++;
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL reset_eligible: got %b exp 0001", grant);
    else n_pass++;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) begin
      logic [N-1:0] want;
      want = N'(1 << i);
      drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
      n_checks++;
      if (grant !== want || grant_idx !== 2'(i))
        $display("FAIL rr_order: got %b/%0d exp %b/%0d", grant, grant_idx, want, i);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_limit();
    logic [N-1:0] want;
    do_reset();
    for (int i = 0; i < MAXO + 2; i++) begin
      want = (i < MAXO) ? 4'b0001 : 4'b0000;
      drive(4'b0001, 1'b0, 1'b0, 2'd0, 1'b0);
      n_checks++;
      if (grant !== want) $display("FAIL limit_fill: cycle %0d got %b exp %b", i, grant, want);
      else n_pass++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      want = (i == 1) ? 4'b0001 : 4'b0000;
      drive(4'b0001, 1'b0, (i == 0), 2'd0, 1'b0);
      n_checks++;
      if (grant !== want) $display("FAIL limit_release: step %0d got %b exp %b", i, grant, want);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b1, 1'b0, 2'd0, 1'b0);
      n_checks++;
      if (grant !== 4'b0000) $display("FAIL almost_full_block: got %b exp 0000", grant);
      else n_pass++;
      tick();
    end
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL almost_full_resume: got %b exp 0010", grant);
    else n_pass++;
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 1'b0, 1'b0, 2'd0, 1'b0);
      tick();
    end
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b0, 1'b1, 2'd2, 1'b1);
      n_checks++;
      if (grant !== 4'b0000 || drained !== 1'b0)
        $display("FAIL drain_wait: rsp %0d got g=%b d=%b exp g=0000 d=0", i, grant, drained);
      else n_pass++;
      tick();
    end
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b1);
    n_checks++;
    if (grant !== 4'b0000 || drained !== 1'b1)
      $display("FAIL drain_done: got g=%b d=%b exp g=0000 d=1", grant, drained);
    else n_pass++;
    tick();
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    n_checks++;
    if (grant !== 4'b0000 || drained !== 1'b1)
      $display("FAIL drain_release_lag: got g=%b d=%b exp g=0000 d=1", grant, drained);
    else n_pass++;
    tick();
    drive(4'b1111, 1'b0, 1'b0, 2'd0, 1'b0);
    n_checks++;
    if (grant !== 4'b1000 || drained !== 1'b0)
      $display("FAIL drain_resume: got g=%b d=%b exp g=1000 d=0", grant, drained);
    else n_pass++;
    tick();
  endtask

  task automatic test_underflow();
    do_reset();
    drive(4'b0000, 1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    for (int i = 0; i < MAXO + 1; i++) begin
      logic [N-1:0] want;
      want = (i < MAXO) ? 4'b0010 : 4'b0000;
      drive(4'b0010, 1'b0, 1'b0, 2'd0, 1'b0);
      n_checks++;
      if (err_underflow !== 1'b1 || grant !== want)
        $display("FAIL underflow_sticky: cycle %0d got e=%b g=%b exp e=1 g=%b",
                 i, err_underflow, grant, want);
      else n_pass++;
      tick();
    end
    do_reset();
    n_checks++;
    if (err_underflow !== 1'b0) $display("FAIL underflow_reset: got %b exp 0", err_underflow);
    else n_pass++;
  endtask

  task automatic test_random();
    logic drn;
    drn = 1'b0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [1:0] rp;
      logic       rv;
      rp = 2'($urandom_range(0, N - 1));
      rv = (m_out[rp] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 24) == 0) drn = ~drn;
      reset_n  = (c != 300);
      stat_sel = 2'($urandom_range(0, N - 1));
      drive(N'($urandom), ($urandom_range(0, 4) == 0), rv, rp, drn);
      exp_q.push_back(exp_grant);
      n_checks++;
      if (grant !== exp_q.pop_front() || grant_idx !== exp_idx || drained !== exp_drained ||
          err_underflow !== exp_err || stat_cnt !== exp_stat)
        $display("FAIL random: cycle %0d got g=%b i=%0d d=%b e=%b s=%0d exp g=%b i=%0d d=%b e=%b s=%0d",
                 c, grant, grant_idx, drained, err_underflow, stat_cnt,
                 exp_grant, exp_idx, exp_drained, exp_err, exp_stat);
      else n_pass++;
      tick();
    end
    reset_n = 1'b1;
  endtask

  task automatic test_stats();
    logic [15:0] want;
    do_reset();
    stat_sel = 2'd3;
    for (int i = 0; i < 65600; i++) begin
      drive(4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
      if (i == 100) begin
        n_checks++;
        if (stat_cnt !== exp_stat) $display("FAIL stats_mid: got %0d exp %0d", stat_cnt, exp_stat);
        else n_pass++;
      end
      tick();
    end
    drive(4'b1000, 1'b0, 1'b1, 2'd3, 1'b0);
    want = STATS ? 16'hFFFF : 16'h0000;
    n_checks++;
    if (stat_cnt !== want || grant !== 4'b1000)
      $display("FAIL stats_saturate: got s=%h g=%b exp s=%h g=1000", stat_cnt, grant, want);
    else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_limit();
    test_almost_full();
    test_drain();
    test_underflow();
    test_random();
    test_stats();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cci_mpf_shim_arb_sched.md
CCI_MPF_SHIM_ARB_SCHED -- requirements
Module: cci_mpf_shim_arb_sched

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter MAX_OUTSTANDING, default 16: per-port limit on in-flight requests; legal range 1..255.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_PORTS  bit p set: port p has a request pending.
REQ-006 tx_almost_full  input  1  downstream request channel cannot accept a request this cycle.
REQ-007 rsp_valid  input  1  a response completes one request this cycle.
REQ-008 rsp_port  input  $clog2(NUM_PORTS)  port index of the completing response; ignored when rsp_valid=0.
REQ-009 drain_req  input  1  level: stop granting and wait for all outstanding to complete.
REQ-010 grant  output  NUM_PORTS  one-hot (or zero) grant; bit p is the dequeue strobe for port p.
REQ-011 grant_idx  output  $clog2(NUM_PORTS)  index of granted port; 0 when grant=0.
REQ-012 drained  output  1  block is in DRAINED state.
REQ-013 err_underflow  output  1  sticky: a response arrived for a port with zero outstanding.
REQ-014 stat_sel  input  $clog2(NUM_PORTS)  port selector for statistics readout.
REQ-015 stat_cnt  output  16  statistics value for port stat_sel.

Function
REQ-016 eligible[p] SHALL equal req_valid[p] AND outstanding[p] < MAX_OUTSTANDING AND NOT tx_almost_full AND state==RUN.
REQ-017 Grant SHALL be combinational from current inputs and registered state (zero-cycle latency); at most one grant bit set per cycle.
REQ-018 Arbitration SHALL be round-robin: search starts at (last_winner+1) mod NUM_PORTS and wraps; first eligible port wins.
REQ-019 last_winner SHALL update only in a cycle with a grant; no grant leaves it unchanged.
REQ-020 outstanding[p] (width $clog2(MAX_OUTSTANDING+1)) SHALL increment on grant[p], decrement on rsp_valid with rsp_port==p, and hold when both occur in the same cycle.
REQ-021 Response for a port with outstanding==0 (and no simultaneous grant to it) SHALL leave the counter at 0 and set err_underflow until reset.
REQ-022 A port at outstanding==MAX_OUTSTANDING SHALL be skipped by arbitration; a response to it in the same cycle does not make it eligible until the next cycle.
REQ-023 States: RUN, DRAIN, DRAINED. RUN->DRAIN when drain_req=1 and any outstanding nonzero; RUN->DRAINED when drain_req=1 and all outstanding zero.
REQ-024 DRAIN->DRAINED when all outstanding counters are zero after this cycle's updates; no grants in DRAIN or DRAINED.
REQ-025 DRAIN or DRAINED -> RUN in the cycle after drain_req deasserts; drained=0 in DRAIN and RUN.
REQ-026 Responses SHALL continue to decrement counters in every state.

Reset
REQ-027 While reset_n=0: state=RUN, last_winner=NUM_PORTS-1 (so port 0 is searched first), all outstanding=0, err_underflow=0, statistics=0.
REQ-028 Outputs during and after reset: grant=0 unless eligible, grant_idx=0, drained=0, err_underflow=0, stat_cnt=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight counts; responses arriving after reset for pre-reset requests SHALL be treated per REQ-021.

Configuration
REQ-030 Macro CCI_MPF_SHIM_ARB_SCHED_STATS_EN: when defined, a 16-bit saturating grant counter per port SHALL increment on each grant to that port (holding at 16'hFFFF) and stat_cnt SHALL present the counter selected by stat_sel combinationally.
REQ-031 When CCI_MPF_SHIM_ARB_SCHED_STATS_EN is undefined, no counters SHALL be built and stat_cnt SHALL be constant 0; all other behaviour unchanged.

Verification
REQ-032 After reset, req_valid=4'b1111 for 4 cycles, no responses -> grant sequence 0001, 0010, 0100, 1000.
REQ-033 MAX_OUTSTANDING=2, req_valid=4'b0001 constantly, no responses -> grants in cycles 1 and 2 only; one rsp_valid rsp_port=0 -> one further grant the following cycle.
REQ-034 tx_almost_full=1 with req_valid=4'b1111 -> grant=0, last_winner unchanged; release -> next grant continues round-robin order.
REQ-035 Port 2 with outstanding=3, drain_req=1 -> state DRAIN, no grants; three responses to port 2 -> drained=1 after the third; drain_req=0 -> RUN next cycle.
REQ-036 rsp_valid=1 rsp_port=1 with outstanding[1]=0 -> err_underflow=1 and remains 1 until reset; outstanding[1] stays 0.
REQ-037 With CCI_MPF_SHIM_ARB_SCHED_STATS_EN, 70000 grants to port 3, stat_sel=3 -> stat_cnt=16'hFFFF; without macro -> stat_cnt=0.
